bf16_div_seq: RTL and testbench

Multi-cycle bfloat16 divider for the FPU, complementing the combinational bf16 add/sub unit. It computes C = A / B with a radix-2 restoring iteration, one quotient bit per cycle, and rounds to nearest-even. It uses the same bf16 encoding and canonical NaN/Inf outputs as the rest of the FPU. Operands are accepted and results returned over valid/ready handshakes, so the block sits beside the add/sub unit behind the FPU issue logic.

---
 rtl/bf16_div_seq_if.sv | 21 ++
 rtl/bf16_div_seq.sv | 161 ++++++++++++++++
 tb/tb_bf16_div_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bf16_div_seq_if.sv
// Operand/result handshake bundle for the sequential bf16 divider.
// The slave modport is the divider; the master modport is its issue logic and consumer.
interface bf16_div_seq_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] c_o;

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o
  );
endinterface

// File: rtl/bf16_div_seq.sv
// Multi-cycle bf16 divider: restoring radix-2 iteration, one quotient bit per cycle,
// round to nearest-even, subnormals flushed, canonical NaN/Inf outputs.
module bf16_div_seq (
  input  logic          clk_i,
  input  logic          rst_i,
  bf16_div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} divState_e;

  divState_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [7:0]  expA_q, expA_d;
  logic [7:0]  expB_q, expB_d;
  logic [7:0]  mantB_q, mantB_d;
  logic [9:0]  rem_q, rem_d;
  logic [9:0]  quo_q, quo_d;
  logic [15:0] c_q, c_d;

  logic [7:0]  aExp, bExp;
  logic [6:0]  aFrac, bFrac;
  logic        aNan, bNan, aInf, bInf, aZero, bZero;
  logic        inSign, isSpecial;
  logic [15:0] specialRes;

  // Subnormals carry exponent 0 and are classified as zero, which flushes them.
  assign aExp   = bus.a_i[14:7];
  assign bExp   = bus.b_i[14:7];
  assign aFrac  = bus.a_i[6:0];
  assign bFrac  = bus.b_i[6:0];
  assign aNan   = (aExp == 8'hFF) && (aFrac != 7'd0);
  assign bNan   = (bExp == 8'hFF) && (bFrac != 7'd0);
  assign aInf   = (aExp == 8'hFF) && (aFrac == 7'd0);
  assign bInf   = (bExp == 8'hFF) && (bFrac == 7'd0);
  assign aZero  = (aExp == 8'h00);
  assign bZero  = (bExp == 8'h00);
  assign inSign = bus.a_i[15] ^ bus.b_i[15];

  assign isSpecial  = aNan | bNan | aInf | bInf | aZero | bZero;
  assign specialRes = (aNan | bNan | (aZero & bZero) | (aInf & bInf)) ? 16'h7FC0 :
                      (aInf | bZero)                                  ? {inSign, 15'h7F80} :
                                                                        {inSign, 15'd0};

  logic        divGe;
  logic [9:0]  remNext;

  assign divGe   = rem_q >= {2'b00, mantB_q};
  assign remNext = divGe ? (rem_q - {2'b00, mantB_q}) : rem_q;

  logic signed [9:0] expPre, expRnd;
  logic [6:0]  sigKeep, fracOut;
  logic        guardBit, stickyBit, roundUp;
  logic [7:0]  sigRnd;
  logic [15:0] roundRes;

  // A quotient below 1.0 has its leading one at q[8], so the kept window shifts down a bit.
  always_comb begin
    expPre = $signed({2'b00, expA_q}) - $signed({2'b00, expB_q}) + 10'sd126
             + $signed({9'd0, quo_q[9]});
    if (quo_q[9]) begin
      sigKeep   = quo_q[8:2];
      guardBit  = quo_q[1];
      stickyBit = quo_q[0] | (rem_q != 10'd0);
    end else begin
      sigKeep   = quo_q[7:1];
      guardBit  = quo_q[0];
      stickyBit = (rem_q != 10'd0);
    end
    roundUp = guardBit & (stickyBit | sigKeep[0]);
    sigRnd  = {1'b0, sigKeep} + {7'd0, roundUp};
    expRnd  = sigRnd[7] ? (expPre + 10'sd1) : expPre;
    fracOut = sigRnd[7] ? 7'd0 : sigRnd[6:0];
    if (expRnd >= 10'sd255) begin
      roundRes = {sign_q, 15'h7F80};
    end else if (expRnd <= 10'sd0) begin
      roundRes = {sign_q, 15'd0};
    end else begin
      roundRes = {sign_q, expRnd[7:0], fracOut};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sign_q  <= 1'b0;
      expA_q  <= 8'd0;
      expB_q  <= 8'd0;
      mantB_q <= 8'd0;
      rem_q   <= 10'd0;
      quo_q   <= 10'd0;
      c_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      expA_q  <= expA_d;
      expB_q  <= expB_d;
      mantB_q <= mantB_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    expA_d  = expA_q;
    expB_d  = expB_q;
    mantB_d = mantB_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          sign_d  = inSign;
          expA_d  = aExp;
          expB_d  = bExp;
          mantB_d = {1'b1, bFrac};
          rem_d   = {3'b001, aFrac};
          quo_d   = 10'd0;
          cnt_d   = 4'd9;
          if (isSpecial) begin
            c_d     = specialRes;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        quo_d = {quo_q[8:0], divGe};
        rem_d = remNext << 1;
        if (cnt_q == 4'd0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ROUND: begin
        c_d     = roundRes;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.c_o         = c_q;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Self-checking bench for bf16_div_seq: directed cases, backpressure, mid-DIV reset,
// then random operands against an exact-integer division reference.
module tb_bf16_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;

  bf16_div_seq_if divIf ();

  bf16_div_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (divIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit isSpecial(input logic [15:0] a, input logic [15:0] b);
    return (a[14:7] == 8'h00) || (a[14:7] == 8'hFF) || (b[14:7] == 8'h00) || (b[14:7] == 8'hFF);
  endfunction

  // Reference: exact quotient of the significands with 20 extra bits plus exact remainder.
  function automatic logic [15:0] refDiv(input logic [15:0] a, input logic [15:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, qq, rr, low, half, sig;
    bit     aNan, bNan, aInf, bInf, aZero, bZero;
    logic [7:0] e8;
    logic [6:0] f7;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    aNan = (ea == 255) && (a[6:0] != 0);
    bNan = (eb == 255) && (b[6:0] != 0);
    aInf = (ea == 255) && (a[6:0] == 0);
    bInf = (eb == 255) && (b[6:0] == 0);
    aZero = (ea == 0);
    bZero = (eb == 0);
    if (aNan || bNan) return 16'h7FC0;
    if ((aZero && bZero) || (aInf && bInf)) return 16'h7FC0;
    if (aInf || bZero) return {s, 15'h7F80};
    if (aZero || bInf) return {s, 15'd0};
    ma = 128 + longint'(a[6:0]);
    mb = 128 + longint'(b[6:0]);
    qq = (ma * (64'd1 << 20)) / mb;
    rr = (ma * (64'd1 << 20)) % mb;
    if (qq >= (64'd1 << 20)) begin
      e = ea - eb + 127; sig = qq / 8192; low = qq % 8192; half = 4096;
    end else begin
      e = ea - eb + 126; sig = qq / 4096; low = qq % 4096; half = 2048;
    end
    if ((low > half) || ((low == half) && ((rr != 0) || (sig % 2 == 1)))) sig++;
    if (sig == 256) begin
      sig = 128;
      e++;
    end
    if (e >= 255) return {s, 15'h7F80};
    if (e <= 0) return {s, 15'd0};
    e8 = 8'(e);
    f7 = 7'(sig - 128);
    return {s, e8, f7};
  endfunction

  function automatic logic [15:0] genOperand();
    logic s;
    logic [7:0] e;
    logic [6:0] f;
    int kind;
    s = 1'($urandom);
    f = 7'($urandom);
    kind = int'($urandom_range(0, 15));
    case (kind)
      0: begin e = 8'h00; f = 7'd0; end
      1: e = 8'h00;
      2: begin e = 8'hFF; f = 7'd0; end
      3: begin e = 8'hFF; f = f | 7'd1; end
      4: e = ($urandom_range(0, 1) == 1) ? 8'd1 : 8'd254;
      5: e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(110, 144));
    endcase
    return {s, e, f};
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expC,
                               input int expLat, input int hold);
    int waitCycles;
    int lat;
    divIf.a_i = a;
    divIf.b_i = b;
    divIf.in_valid_i = 1'b1;
    waitCycles = 0;
    while (!divIf.in_ready_o && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("acceptReady", 32'(divIf.in_ready_o), 32'd1);
    @(posedge clk); #1;
    lat = 1;
    // Garbage on the operand bus while busy must never be accepted.
    while (!divIf.out_valid_o && lat < 40) begin
      divIf.in_valid_i = 1'($urandom_range(0, 1));
      divIf.a_i = 16'($urandom);
      divIf.b_i = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("outValid", 32'(divIf.out_valid_o), 32'd1);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("result", 32'(divIf.c_o), 32'(expC));
    checkOutput("busyReady", 32'(divIf.in_ready_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      divIf.in_valid_i = 1'b1;
      divIf.a_i = 16'($urandom);
      divIf.b_i = 16'($urandom);
      @(posedge clk); #1;
      checkOutput("holdResult", 32'(divIf.c_o), 32'(expC));
      checkOutput("holdReady", 32'(divIf.in_ready_o), 32'd0);
      checkOutput("holdValid", 32'(divIf.out_valid_o), 32'd1);
    end
    divIf.out_ready_i = 1'b1;
    @(posedge clk); #1;
    divIf.out_ready_i = 1'b0;
    divIf.in_valid_i = 1'b0;
    checkOutput("postValid", 32'(divIf.out_valid_o), 32'd0);
    checkOutput("postReady", 32'(divIf.in_ready_o), 32'd1);
  endtask

  task automatic resetMidDiv();
    divIf.a_i = 16'h3F80;
    divIf.b_i = 16'h4040;
    divIf.in_valid_i = 1'b1;
    @(posedge clk); #1;
    divIf.in_valid_i = 1'b0;
    checkOutput("midDivBusy", 32'(divIf.in_ready_o), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstReady", 32'(divIf.in_ready_o), 32'd1);
    checkOutput("midRstValid", 32'(divIf.out_valid_o), 32'd0);
    checkOutput("midRstResult", 32'(divIf.c_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [15:0] dirA [12] = '{16'h3F80, 16'h4040, 16'h3F80, 16'h3FC0, 16'h3F80, 16'hBF80,
                             16'h0000, 16'h7FC1, 16'h3F80, 16'h0040, 16'h7F00, 16'h0080};
  logic [15:0] dirB [12] = '{16'h4000, 16'h4040, 16'h4040, 16'h3FC0, 16'h0000, 16'h0000,
                             16'h0000, 16'h3F80, 16'hFF80, 16'h3F80, 16'h0080, 16'h4000};
  logic [15:0] dirC [12] = '{16'h3F00, 16'h3F80, 16'h3EAB, 16'h3F80, 16'h7F80, 16'hFF80,
                             16'h7FC0, 16'h7FC0, 16'h8000, 16'h0000, 16'h7F80, 16'h0000};
  int          dirLat [12] = '{12, 12, 12, 12, 1, 1, 1, 1, 1, 1, 12, 12};

  initial begin
    rst = 1'b1;
    divIf.in_valid_i  = 1'b0;
    divIf.out_ready_i = 1'b0;
    divIf.a_i = 16'd0;
    divIf.b_i = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", 32'(divIf.in_ready_o), 32'd1);
    checkOutput("rstValid", 32'(divIf.out_valid_o), 32'd0);
    checkOutput("rstResult", 32'(divIf.c_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(dirA[i], dirB[i], dirC[i], dirLat[i], 0);
    end

    applyStimulus(16'h4040, 16'h3F80, 16'h4040, 12, 5);
    applyStimulus(16'h3F80, 16'h4000, 16'h3F00, 12, 0);

    resetMidDiv();
    applyStimulus(16'h4000, 16'h3F80, 16'h4000, 12, 0);

    for (int n = 0; n < 80; n++) begin
      logic [15:0] ra, rb;
      ra = genOperand();
      rb = genOperand();
      applyStimulus(ra, rb, refDiv(ra, rb), isSpecial(ra, rb) ? 1 : 12, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
